diag_bus_arbiter: RTL and testbench

- Sits directly downstream of the diagnostics block, between its RAM-control outputs and the physical memory bus.
- Converts the diagnostics halt request into a 6502-safe RDY handshake.
- Grants the memory bus to diagnostics only once the CPU is provably stalled.
- Stretches the one-clock diagnostic write strobe into a timed SRAM write pulse, and hands the bus back to the CPU cleanly on resume.

---
 rtl/diag_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_diag_bus_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diag_bus_arbiter.sv
// Memory-bus arbiter between a 6502 CPU and the diagnostics block.
// Stalls the CPU via RDY, grants the bus, and stretches diag writes.
module diag_bus_arbiter #(
  parameter int HALT_SETTLE_CYCLES = 2,
  parameter int WE_PULSE_CLKS      = 3
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        halt_req,
  input  logic        diag_cs,
  input  logic        diag_we,
  input  logic [15:0] diag_address,
  input  logic [7:0]  diag_wdata,
  output logic [7:0]  diag_rdata,
  input  logic        cpu_phi2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        bus_owned,
  output logic [7:0]  dropped_writes
);

  typedef enum logic [2:0] {
    CPU_OWN,
    HALT_WAIT,
    HALT_SETTLE,
    DIAG_OWN,
    WRITE_PULSE,
    RELEASE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(HALT_SETTLE_CYCLES);
  localparam logic [3:0] PULSE_LAST  = 4'(WE_PULSE_CLKS - 1);

  state_t      state;
  logic [2:0]  phi2_sync;
  logic [1:0]  rw_sync;
  logic        diag_we_d;
  logic [7:0]  settle_cnt;
  logic [3:0]  pulse_cnt;
  logic        rel_pend;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  logic phi2_fall;
  logic rw_s;
  logic we_edge;

  assign phi2_fall = ~phi2_sync[1] & phi2_sync[2];
  assign rw_s      = rw_sync[1];
  assign we_edge   = diag_we & ~diag_we_d;

  always_comb begin
    mem_address = cpu_address;
    mem_wdata   = cpu_wdata;
    mem_we      = cpu_phi2 & ~cpu_rw;
    mem_oe      = cpu_rw;
    if (bus_owned) begin
      if (state == WRITE_PULSE) begin
        mem_address = wr_addr;
        mem_wdata   = wr_data;
        mem_we      = 1'b1;
        mem_oe      = 1'b0;
      end else begin
        mem_address = diag_address;
        mem_wdata   = diag_wdata;
        mem_we      = 1'b0;
        mem_oe      = diag_cs;
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!fpga_reset) begin
      state          <= CPU_OWN;
      phi2_sync      <= '0;
      rw_sync        <= '0;
      diag_we_d      <= 1'b0;
      settle_cnt     <= '0;
      pulse_cnt      <= '0;
      rel_pend       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      cpu_rdy        <= 1'b1;
      bus_owned      <= 1'b0;
      diag_rdata     <= '0;
      dropped_writes <= '0;
    end else begin
      phi2_sync <= {phi2_sync[1:0], cpu_phi2};
      rw_sync   <= {rw_sync[0], cpu_rw};
      diag_we_d <= diag_we;

      if (we_edge && state != DIAG_OWN && dropped_writes != 8'hFF)
        dropped_writes <= dropped_writes + 8'd1;

      if (state == DIAG_OWN)
        diag_rdata <= mem_rdata;

      unique case (state)
        CPU_OWN: begin
          cpu_rdy <= 1'b1;
          if (halt_req) begin
            state   <= HALT_WAIT;
            cpu_rdy <= 1'b0;
          end
        end
        HALT_WAIT: begin
          // the 6502 only stalls on a read cycle
          if (!halt_req) begin
            state <= RELEASE;
          end else if (phi2_fall && rw_s) begin
            settle_cnt <= '0;
            state      <= HALT_SETTLE;
          end
        end
        HALT_SETTLE: begin
          if (!halt_req) begin
            state <= RELEASE;
          end else if (phi2_fall) begin
            if (settle_cnt + 8'd1 >= SETTLE_LAST) begin
              state     <= DIAG_OWN;
              bus_owned <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        DIAG_OWN: begin
          if (we_edge && diag_cs) begin
            wr_addr   <= diag_address;
            wr_data   <= diag_wdata;
            pulse_cnt <= '0;
            rel_pend  <= ~halt_req;
            state     <= WRITE_PULSE;
          end else if (!halt_req) begin
            state     <= RELEASE;
            bus_owned <= 1'b0;
          end
        end
        WRITE_PULSE: begin
          if (!halt_req)
            rel_pend <= 1'b1;
          if (pulse_cnt == PULSE_LAST) begin
            if (rel_pend || !halt_req) begin
              state     <= RELEASE;
              bus_owned <= 1'b0;
            end else begin
              state <= DIAG_OWN;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        RELEASE: begin
          cpu_rdy <= 1'b1;
          state   <= CPU_OWN;
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_diag_bus_arbiter.sv
// Directed bench for diag_bus_arbiter: halt, owned read/write,
// resume, dropped-write saturation and reset during a write pulse.
`timescale 1ns/1ps
module tb_diag_bus_arbiter;

  logic        clk = 1'b0;
  logic        fpga_reset = 1'b1;
  logic        halt_req = 1'b0;
  logic        diag_cs = 1'b0;
  logic        diag_we = 1'b0;
  logic [15:0] diag_address = '0;
  logic [7:0]  diag_wdata = '0;
  logic [7:0]  diag_rdata;
  logic        cpu_phi2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_address = 16'hBEEF;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rdy;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic        mem_oe;
  logic        bus_owned;
  logic [7:0]  dropped_writes;

  int total = 0;
  int bad = 0;

  diag_bus_arbiter #(
    .HALT_SETTLE_CYCLES(2),
    .WE_PULSE_CLKS(3)
  ) dut (
    .fpga_clk(clk),
    .fpga_reset(fpga_reset),
    .halt_req(halt_req),
    .diag_cs(diag_cs),
    .diag_we(diag_we),
    .diag_address(diag_address),
    .diag_wdata(diag_wdata),
    .diag_rdata(diag_rdata),
    .cpu_phi2(cpu_phi2),
    .cpu_rw(cpu_rw),
    .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we),
    .mem_oe(mem_oe),
    .bus_owned(bus_owned),
    .dropped_writes(dropped_writes)
  );

  always #5 clk = ~clk;

  // memory model: one marked location, everything else address-derived
  always_comb begin
    mem_rdata = mem_address[7:0] ^ 8'h5A;
    if (mem_address == 16'h1234)
      mem_rdata = 8'hA5;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one 16-clock 6502 cycle; rw/address held briefly past phi2 fall
  task automatic cpu_cycle(input logic rw, input logic [15:0] a);
    cpu_phi2 = 1'b0;
    repeat (3) step();
    cpu_rw = rw;
    cpu_address = a;
    cpu_wdata = a[7:0];
    repeat (5) step();
    cpu_phi2 = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    fpga_reset = 1'b0;
    repeat (2) step();
    total++;
    if (cpu_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_rdy got=%b want=1", cpu_rdy);
    end
    total++;
    if (bus_owned !== 1'b0) begin
      bad++; $display("FAIL reset_owned got=%b want=0", bus_owned);
    end
    total++;
    if (diag_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_rdata got=%h want=00", diag_rdata);
    end
    total++;
    if (dropped_writes !== 8'h00) begin
      bad++; $display("FAIL reset_dropped got=%h want=00", dropped_writes);
    end
    total++;
    if (mem_address !== 16'hBEEF) begin
      bad++; $display("FAIL reset_mux got=%h want=beef", mem_address);
    end
    fpga_reset = 1'b1;
    step();
  endtask

  task automatic test_halt_stall();
    cpu_cycle(1'b1, 16'h7FFF);
    cpu_cycle(1'b0, 16'h8000);
    total++;
    if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_address !== 16'h8000) begin
      bad++;
      $display("FAIL cpu_write_mux got we=%b oe=%b a=%h want we=1 oe=0 a=8000",
               mem_we, mem_oe, mem_address);
    end
    halt_req = 1'b1;
    step();
    total++;
    if (cpu_rdy !== 1'b0) begin
      bad++; $display("FAIL halt_rdy got=%b want=0", cpu_rdy);
    end
    cpu_cycle(1'b1, 16'h8001);
    cpu_cycle(1'b1, 16'h8002);
    total++;
    if (bus_owned !== 1'b0) begin
      bad++; $display("FAIL settle_early0 got=%b want=0", bus_owned);
    end
    cpu_cycle(1'b1, 16'h8003);
    total++;
    if (bus_owned !== 1'b0) begin
      bad++; $display("FAIL settle_early1 got=%b want=0", bus_owned);
    end
    cpu_cycle(1'b1, 16'h8004);
    total++;
    if (bus_owned !== 1'b1 || cpu_rdy !== 1'b0) begin
      bad++;
      $display("FAIL grant got owned=%b rdy=%b want owned=1 rdy=0",
               bus_owned, cpu_rdy);
    end
  endtask

  task automatic test_owned_read();
    diag_cs = 1'b1;
    diag_address = 16'h1234;
    #1;
    total++;
    if (mem_address !== 16'h1234 || mem_oe !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL read_bus got a=%h oe=%b we=%b want a=1234 oe=1 we=0",
               mem_address, mem_oe, mem_we);
    end
    step();
    total++;
    if (diag_rdata !== 8'hA5) begin
      bad++; $display("FAIL read_a5 got=%h want=a5", diag_rdata);
    end
    diag_address = 16'h0042;
    step();
    total++;
    if (diag_rdata !== 8'h18) begin
      bad++; $display("FAIL read_18 got=%h want=18", diag_rdata);
    end
  endtask

  task automatic test_stretched_write();
    int hi;
    int unstable;
    hi = 0;
    unstable = 0;
    diag_address = 16'h0200;
    diag_wdata = 8'h3C;
    diag_we = 1'b1;
    step();
    diag_we = 1'b0;
    diag_address = 16'h0300;
    diag_wdata = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      if (mem_we === 1'b1) begin
        hi++;
        if (mem_address !== 16'h0200 || mem_wdata !== 8'h3C || mem_oe !== 1'b0)
          unstable++;
      end
      if (i == 1) diag_we = 1'b1;
      if (i == 2) diag_we = 1'b0;
      step();
    end
    total++;
    if (hi != 3) begin
      bad++; $display("FAIL write_len got=%0d want=3", hi);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL write_stable got=%0d want=0", unstable);
    end
    total++;
    if (dropped_writes !== 8'd1) begin
      bad++; $display("FAIL pulse_drop got=%0d want=1", dropped_writes);
    end
    total++;
    if (mem_we !== 1'b0 || bus_owned !== 1'b1) begin
      bad++;
      $display("FAIL after_write got we=%b owned=%b want we=0 owned=1",
               mem_we, bus_owned);
    end
  endtask

  task automatic test_held_we();
    int hi;
    hi = 0;
    diag_address = 16'h0201;
    diag_wdata = 8'h77;
    diag_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_we === 1'b1) hi++;
    end
    diag_we = 1'b0;
    step();
    total++;
    if (hi != 3) begin
      bad++; $display("FAIL held_we got=%0d want=3", hi);
    end
    total++;
    if (dropped_writes !== 8'd1) begin
      bad++; $display("FAIL held_drop got=%0d want=1", dropped_writes);
    end
  endtask

  task automatic test_resume();
    int hi;
    int first_bo;
    int first_rdy;
    hi = 0;
    first_bo = 0;
    first_rdy = 0;
    diag_address = 16'h0210;
    diag_wdata = 8'h11;
    diag_we = 1'b1;
    step();
    diag_we = 1'b0;
    halt_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (mem_we === 1'b1) hi++;
      if (bus_owned === 1'b0 && first_bo == 0) first_bo = i;
      if (cpu_rdy === 1'b1 && first_rdy == 0) first_rdy = i;
      step();
    end
    total++;
    if (hi != 3) begin
      bad++; $display("FAIL resume_len got=%0d want=3", hi);
    end
    total++;
    if (first_bo != 4) begin
      bad++; $display("FAIL resume_owned got=%0d want=4", first_bo);
    end
    total++;
    if (first_rdy != 5) begin
      bad++; $display("FAIL resume_rdy got=%0d want=5", first_rdy);
    end
    cpu_address = 16'h4321;
    cpu_rw = 1'b0;
    #1;
    total++;
    if (mem_address !== 16'h4321 || mem_we !== 1'b1 || mem_oe !== 1'b0) begin
      bad++;
      $display("FAIL resume_mux got a=%h we=%b oe=%b want a=4321 we=1 oe=0",
               mem_address, mem_we, mem_oe);
    end
    cpu_rw = 1'b1;
    step();
  endtask

  task automatic test_dropped();
    int stray;
    stray = 0;
    cpu_rw = 1'b1;
    for (int i = 0; i < 300; i++) begin
      diag_we = 1'b1;
      step();
      if (mem_we !== 1'b0) stray++;
      diag_we = 1'b0;
      step();
      if (mem_we !== 1'b0) stray++;
    end
    total++;
    if (dropped_writes !== 8'd255) begin
      bad++; $display("FAIL drop_sat got=%0d want=255", dropped_writes);
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL drop_we got=%0d want=0", stray);
    end
  endtask

  task automatic test_reset_mid_pulse();
    fpga_reset = 1'b0;
    step();
    fpga_reset = 1'b1;
    step();
    total++;
    if (dropped_writes !== 8'd0) begin
      bad++; $display("FAIL drop_clear got=%0d want=0", dropped_writes);
    end
    halt_req = 1'b1;
    for (int i = 0; i < 8 && bus_owned !== 1'b1; i++)
      cpu_cycle(1'b1, 16'h9000 + 16'(i));
    total++;
    if (bus_owned !== 1'b1) begin
      bad++; $display("FAIL reacquire got=%b want=1", bus_owned);
    end
    diag_address = 16'h1234;
    step();
    total++;
    if (diag_rdata !== 8'hA5) begin
      bad++; $display("FAIL reread got=%h want=a5", diag_rdata);
    end
    diag_address = 16'h0220;
    diag_wdata = 8'h5C;
    diag_we = 1'b1;
    step();
    diag_we = 1'b0;
    total++;
    if (mem_we !== 1'b1 || mem_address !== 16'h0220) begin
      bad++;
      $display("FAIL rst_pulse got we=%b a=%h want we=1 a=0220",
               mem_we, mem_address);
    end
    step();
    fpga_reset = 1'b0;
    step();
    total++;
    if (mem_we !== 1'b0 || mem_address !== cpu_address) begin
      bad++;
      $display("FAIL rst_abort got we=%b a=%h want we=0 a=%h",
               mem_we, mem_address, cpu_address);
    end
    total++;
    if (bus_owned !== 1'b0 || cpu_rdy !== 1'b1 || diag_rdata !== 8'h00) begin
      bad++;
      $display("FAIL rst_state got owned=%b rdy=%b rdata=%h want 0 1 00",
               bus_owned, cpu_rdy, diag_rdata);
    end
    fpga_reset = 1'b1;
    halt_req = 1'b0;
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_halt_stall();
    test_owned_read();
    test_stretched_write();
    test_held_we();
    test_resume();
    test_dropped();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
